// File: rtl/bip_result_tx.sv
// Result transmitter for the BIP core: snapshots accumulator, PC and run length
// when the program finishes and sends them as a 7-byte 8N1 serial frame.
module bip_result_tx #(
  parameter int          NB_INSTRUCTION = 16,
  parameter int          NB_ADDR        = 11,
  parameter int          NB_CYCLES      = 16,
  parameter int          CLKS_PER_BIT   = 16,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NB_INSTRUCTION-1:0] i_accumulator,
  input  logic [NB_ADDR-1:0]        i_program_counter,
  input  logic                      i_program_done,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int               NB_CLK    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [NB_CLK-1:0] CLK_LAST = NB_CLK'(CLKS_PER_BIT - 1);
  localparam logic [NB_CYCLES-1:0] CYC_MAX = {NB_CYCLES{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                    state;
  logic                      done_d;
  logic                      trig;
  logic [NB_CYCLES-1:0]      cycle_cnt;
  logic [NB_INSTRUCTION-1:0] acc_s;
  logic [NB_ADDR-1:0]        pc_s;
  logic [NB_CYCLES-1:0]      cyc_s;
  logic [15:0]               pc_ext;
  logic [15:0]               cyc_ext;
  logic [2:0]                byte_idx;
  logic [2:0]                bit_idx;
  logic [NB_CLK-1:0]         clk_cnt;
  logic [7:0]                cur_byte;
  logic                      bit_last;

  assign trig     = i_program_done & ~done_d;
  assign pc_ext   = 16'(pc_s);
  assign cyc_ext  = 16'(cyc_s);
  assign bit_last = (clk_cnt == CLK_LAST);

  // Run-length counter: counts done-low clocks and sticks at full scale.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_cnt <= '0;
    end else if (!i_program_done && cycle_cnt != CYC_MAX) begin
      cycle_cnt <= cycle_cnt + NB_CYCLES'(1);
    end
  end

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = acc_s[15:8];
      3'd2:    cur_byte = acc_s[7:0];
      3'd3:    cur_byte = pc_ext[15:8];
      3'd4:    cur_byte = pc_ext[7:0];
      3'd5:    cur_byte = cyc_ext[15:8];
      3'd6:    cur_byte = cyc_ext[7:0];
      default: cur_byte = HEADER;
    endcase
  end

  // o_tx is loaded one step ahead so each bit value appears on the edge its slot begins.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      o_tx         <= 1'b1;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      done_d       <= 1'b0;
      byte_idx     <= '0;
      bit_idx      <= '0;
      clk_cnt      <= '0;
    end else begin
      done_d       <= i_program_done;
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (trig) begin
            acc_s    <= i_accumulator;
            pc_s     <= i_program_counter;
            cyc_s    <= cycle_cnt;
            state    <= START;
            byte_idx <= '0;
            bit_idx  <= '0;
            clk_cnt  <= '0;
            o_tx     <= 1'b0;
            o_busy   <= 1'b1;
          end
        end
        START: begin
          if (bit_last) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            o_tx    <= cur_byte[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + NB_CLK'(1);
          end
        end
        DATA: begin
          if (bit_last) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + NB_CLK'(1);
          end
        end
        STOP: begin
          if (bit_last) begin
            clk_cnt <= '0;
            if (byte_idx != 3'd6) begin
              byte_idx <= byte_idx + 3'd1;
              o_tx     <= 1'b0;
              state    <= START;
            end else begin
              o_tx         <= 1'b1;
              o_busy       <= 1'b0;
              o_frame_done <= 1'b1;
              state        <= IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + NB_CLK'(1);
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bip_result_tx.sv
// Directed bench for bip_result_tx: two instances (16-bit and 4-bit cycle counter)
// share stimulus; serial traces are recorded and compared to hand-computed frames.
module tb_bip_result_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] acc;
  logic [10:0] pc;
  logic        done;
  logic        tx_a, busy_a, fd_a;
  logic        tx_b, busy_b, fd_b;

  int checks   = 0;
  int failures = 0;

  logic tr_tx_a   [0:399];
  logic tr_tx_b   [0:399];
  logic tr_busy_a [0:399];
  logic tr_fd_a   [0:399];

  always #5 clk = ~clk;

  bip_result_tx #(.CLKS_PER_BIT(4)) dut_a (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_accumulator    (acc),
    .i_program_counter(pc),
    .i_program_done   (done),
    .o_tx             (tx_a),
    .o_busy           (busy_a),
    .o_frame_done     (fd_a)
  );

  bip_result_tx #(.CLKS_PER_BIT(4), .NB_CYCLES(4)) dut_b (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_accumulator    (acc),
    .i_program_counter(pc),
    .i_program_done   (done),
    .o_tx             (tx_b),
    .o_busy           (busy_b),
    .o_frame_done     (fd_b)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset, hold done low for low_cycles clocks, then raise done with the given inputs.
  task automatic apply_stimulus(input logic [15:0] a, input logic [10:0] p, input int low_cycles);
    do_reset();
    repeat (low_cycles) @(negedge clk);
    acc  = a;
    pc   = p;
    done = 1'b1;
  endtask

  // Sample 0 is taken just after the detection edge; drop_at >= 0 pulses done low mid-frame.
  task automatic record_trace(input int drop_at);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      tr_tx_a[i]   = tx_a;
      tr_tx_b[i]   = tx_b;
      tr_busy_a[i] = busy_a;
      tr_fd_a[i]   = fd_a;
      if (drop_at >= 0) begin
        if (i == drop_at) begin
          done = 1'b0;
        end else if (i == drop_at + 3) begin
          done = 1'b1;
          acc  = 16'hFFFF;
          pc   = 11'h7FF;
        end
      end
    end
  endtask

  function automatic logic [7:0] decode_byte(input int b, input logic sel_b);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      v[k] = sel_b ? tr_tx_b[b*40 + 4 + k*4 + 2] : tr_tx_a[b*40 + 4 + k*4 + 2];
    end
    return v;
  endfunction

  task automatic check_bytes(input string tag, input logic sel_b, input logic [55:0] exp_bytes);
    for (int b = 0; b < 7; b++) begin
      check_output($sformatf("%s byte%0d", tag, b), 32'(decode_byte(b, sel_b)), 32'(exp_bytes[55 - 8*b -: 8]));
    end
  endtask

  task automatic check_frame_a(input string tag, input logic [55:0] exp_bytes);
    int         bad;
    int         busy_cnt;
    int         fd_cnt;
    int         slot;
    logic [7:0] eb;
    logic       ev;
    check_bytes(tag, 1'b0, exp_bytes);
    check_output({tag, " start_bit"}, 32'({tr_tx_a[0], tr_tx_a[1], tr_tx_a[2], tr_tx_a[3], tr_tx_a[4]}), 32'h01);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      ev = 1'b1;
      if (i < 280) begin
        eb   = exp_bytes[55 - 8*(i/40) -: 8];
        slot = (i % 40) / 4;
        if (slot == 0)      ev = 1'b0;
        else if (slot <= 8) ev = eb[slot-1];
        else                ev = 1'b1;
      end
      if (tr_tx_a[i] !== ev) bad++;
    end
    check_output({tag, " tx_waveform_errors"}, 32'(bad), 32'd0);
    busy_cnt = 0;
    fd_cnt   = 0;
    for (int i = 0; i < 400; i++) begin
      if (tr_busy_a[i] === 1'b1) busy_cnt++;
      if (tr_fd_a[i] === 1'b1)   fd_cnt++;
    end
    check_output({tag, " busy_clocks"}, 32'(busy_cnt), 32'd280);
    check_output({tag, " busy_edges"}, 32'({tr_busy_a[0], tr_busy_a[279], tr_busy_a[280]}), 32'b110);
    check_output({tag, " frame_done_count"}, 32'(fd_cnt), 32'd1);
    check_output({tag, " frame_done_at_end"}, 32'(tr_fd_a[280]), 32'd1);
  endtask

  initial begin
    int extra_busy;
    reset = 1'b1;
    done  = 1'b0;
    acc   = 16'h1234;
    pc    = 11'h00A;

    // Reset state and idle line for 10 clocks, then a basic frame after 20 low cycles.
    @(negedge clk);
    check_output("reset_state_a", 32'({tx_a, busy_a, fd_a}), 32'b100);
    check_output("reset_state_b", 32'({tx_b, busy_b, fd_b}), 32'b100);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output($sformatf("idle_%0d", i), 32'({tx_a, busy_a, fd_a}), 32'b100);
    end
    repeat (10) @(negedge clk);
    done = 1'b1;
    record_trace(-1);
    check_frame_a("basic", 56'hA5_1234_000A_0014);
    check_bytes("saturate", 1'b1, 56'hA5_1234_000A_000F);

    // Done held high with a mid-frame glitch and input change: one frame, snapshot data.
    apply_stimulus(16'h1234, 11'h00A, 20);
    record_trace(100);
    check_frame_a("glitch", 56'hA5_1234_000A_0014);
    check_bytes("glitch_b", 1'b1, 56'hA5_1234_000A_000F);
    extra_busy = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy_a !== 1'b0 || busy_b !== 1'b0) extra_busy++;
    end
    check_output("no_second_frame", 32'(extra_busy), 32'd0);

    // Reset inside byte 3 aborts the frame; a fresh frame then carries cycle count 5.
    apply_stimulus(16'h1234, 11'h00A, 20);
    repeat (131) @(negedge clk);
    check_output("pre_abort", 32'({tx_a, busy_a}), 32'b01);
    reset = 1'b1;
    done  = 1'b0;
    @(negedge clk);
    check_output("abort_a", 32'({tx_a, busy_a, fd_a}), 32'b100);
    check_output("abort_b", 32'({tx_b, busy_b, fd_b}), 32'b100);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    acc  = 16'hBEEF;
    pc   = 11'h7FF;
    done = 1'b1;
    record_trace(-1);
    check_frame_a("after_abort", 56'hA5_BEEF_07FF_0005);
    check_bytes("after_abort_b", 1'b1, 56'hA5_BEEF_07FF_0005);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
